// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select and one-hot grant of a shared 4:1 one-bit mux.
// Tenure is capped at HOLD_MAX cycles whenever another requester is waiting.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       valid,
    output logic       dbg_state
);

    localparam int CW = $clog2(HOLD_MAX + 1);

    // Handshake: req[k] is a level request; gnt[k] follows on the next edge. A dropped
    // req keeps its grant for one more cycle, which that requester must ignore.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      s_q, s_d;

    logic [3:0]      others;
    logic [1:0]      win_idle, win_next, win;
    logic            do_grant;

    // First asserted bit of r searching start, start+1, ... (mod 4); r must be non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // While granted, s_q is the owner and gnt_q its one-hot mask.
    assign others   = req & ~gnt_q;
    assign win_idle = rr_pick(req, ptr_q);
    assign win_next = rr_pick(others, s_q + 2'd1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        s_d      = s_q;
        do_grant = 1'b0;
        win      = win_next;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    win      = win_idle;
                end
            end
            GRANT: begin
                if ((req & gnt_q) == 4'b0000) begin
                    if (|others) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (cnt_q < CW'(HOLD_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (|others) begin
                    do_grant = 1'b1;
                end else begin
                    cnt_d = CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        if (do_grant) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win;
            s_d     = win;
            cnt_d   = CW'(1);
            ptr_d   = win + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            s_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
        end
    end

    assign gnt       = gnt_q;
    assign s         = s_q;
    assign valid     = |gnt_q;
    assign dbg_state = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random requests against an
// integer-based round-robin reference model with an expected-output queue.
module tb_mux4_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {state, valid, s, gnt} after each edge.
    logic [7:0] exp_q[$];

    // Reference model: owner = -1 when idle.
    int         m_owner;
    int         m_ptr;
    int         m_cnt;
    logic [1:0] m_s;

    mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .s         (s),
        .valid     (valid),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    function automatic void m_grant(input int w);
        m_owner = w;
        m_s     = 2'(w);
        m_cnt   = 1;
        m_ptr   = (w + 1) % 4;
    endfunction

    function automatic void m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_s     = 2'd0;
    endfunction

    function automatic void m_step(input logic [3:0] r);
        logic [3:0] oth;
        if (m_owner < 0) begin
            if (r != 4'b0000) m_grant(pick(r, m_ptr));
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                if (oth != 4'b0000) m_grant(pick(oth, (m_owner + 1) % 4));
                else m_owner = -1;
            end else if (m_cnt < HOLD) begin
                m_cnt++;
            end else if (oth != 4'b0000) begin
                m_grant(pick(oth, (m_owner + 1) % 4));
            end else begin
                m_cnt = 1;
            end
        end
    endfunction

    function automatic logic [7:0] m_out();
        if (m_owner < 0) return {2'b00, m_s, 4'b0000};
        return {2'b11, m_s, 4'(1 << m_owner)};
    endfunction

    // Starts and ends on a falling edge; outputs sampled 1 time unit after the rising edge.
    task automatic drive_cycle(input logic [3:0] r);
        logic [7:0] e;
        req = r;
        m_step(r);
        exp_q.push_back(m_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("gnt", gnt, e[3:0]);
        check("s", s, e[5:4]);
        check("valid", valid, e[6]);
        check("state", dbg_state, e[7]);
        check("onehot", ($countones(gnt) <= 1), 1);
        @(negedge clk);
    endtask

    // Asserts reset away from the rising edge, so the clear must be asynchronous.
    task automatic apply_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        m_reset();
        #1;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_s", s, 2'b00);
        check("rst_valid", valid, 1'b0);
        check("rst_state", dbg_state, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r;

        // T1: reset with requests present, before any clock edge
        apply_reset(4'b1010);
        drive_cycle(4'b0000);

        // T2: lone requester held across several tenure wraps
        for (int i = 0; i < 22; i++) begin
            drive_cycle(4'b0100);
            check("t2_gnt", gnt, 4'b0100);
            check("t2_s", s, 2'b10);
        end
        drive_cycle(4'b0000);
        drive_cycle(4'b0000);
        check("t2_idle", gnt, 4'b0000);
        check("t2_s_hold", s, 2'b10);

        // T3: full contention rotates every HOLD cycles
        apply_reset(4'b0000);
        for (int c = 0; c < 20; c++) begin
            drive_cycle(4'b1111);
            check("t3_seq", gnt, 32'(1 << ((c / HOLD) % 4)));
        end

        // T4: early release hands over with no idle bubble
        apply_reset(4'b0000);
        drive_cycle(4'b0010);
        drive_cycle(4'b0010);
        check("t4_owner", gnt, 4'b0010);
        drive_cycle(4'b1000);
        check("t4_handover", gnt, 4'b1000);
        check("t4_valid", valid, 1'b1);

        // T5: pointer fairness after idle
        apply_reset(4'b0000);
        drive_cycle(4'b0100);
        drive_cycle(4'b0000);
        check("t5_idle", gnt, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(4'b0101);
            if (c < HOLD) check("t5_first", gnt, 4'b0001);
            else check("t5_switch", gnt, 4'b0100);
        end

        // T6: reset during tenure of requester 3
        apply_reset(4'b0000);
        drive_cycle(4'b1000);
        drive_cycle(4'b1000);
        check("t6_owner", gnt, 4'b1000);
        apply_reset(4'b1111);
        drive_cycle(4'b1111);
        check("t6_restart", gnt, 4'b0001);

        // Random phase with occasional resets
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                apply_reset(4'($urandom));
            end else begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom);
                drive_cycle(r);
            end
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
